// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, filters async lock, releases system reset after stable lock.
// Latency: lock pin to outputs 3 cycles (2 sync + 1 register); no backpressure, status outputs only.
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 250000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       force_relock,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_count,
   output logic [2:0] state
);

   localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CNT_W = (MAX_C > 2) ? $clog2(MAX_C) : 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [31:0]      MAX_R32     = 32'(MAX_RETRIES);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d, retry_inc;
   logic             sync_q, lk_q;
   logic             attempt_fail;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      retry_d      = retry_q;
      attempt_fail = 1'b0;
      retry_inc    = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

      if (force_relock) begin
         state_d = ST_PLL_RST;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               if (cnt_q == RST_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_WAIT_LOCK: begin
               if (lk_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == LOCK_LAST) begin
                  attempt_fail = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            // lk is tested before the count so a drop on the final cycle still fails
            ST_STABLE: begin
               if (!lk_q) begin
                  attempt_fail = 1'b1;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_RUN: begin
               if (!lk_q) begin
                  state_d = ST_PLL_RST;
                  cnt_d   = '0;
               end
            end
            ST_FAIL: ;
            default: begin
               state_d = ST_PLL_RST;
               cnt_d   = '0;
            end
         endcase

         if (attempt_fail) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            if (MAX_RETRIES != 0 && {28'd0, retry_inc} >= MAX_R32)
               state_d = ST_FAIL;
            else
               state_d = ST_PLL_RST;
         end
      end

      pll_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      sys_rst_n_d = (state_d == ST_RUN);
      ready_d     = (state_d == ST_RUN);
      fail_d      = (state_d == ST_FAIL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         sync_q      <= 1'b0;
         lk_q        <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         sync_q      <= pll_locked;
         lk_q        <= sync_q;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_rst_n   = sys_rst_n_q;
   assign ready       = ready_q;
   assign fail        = fail_q;
   assign retry_count = retry_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed lock scenarios plus random lock/relock traffic.
module tb_pll_lock_supervisor;

   localparam int RST_C  = 4;
   localparam int LOCK_T = 20;
   localparam int STAB_C = 8;
   localparam int MAX_R  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       force_relock;
   logic       pll_rst, sys_rst_n, ready, fail;
   logic [3:0] retry_count;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   pll_lock_supervisor #(
      .RST_CYCLES   (RST_C),
      .LOCK_TIMEOUT (LOCK_T),
      .STABLE_CYCLES(STAB_C),
      .MAX_RETRIES  (MAX_R)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .force_relock(force_relock),
      .pll_rst     (pll_rst),
      .sys_rst_n   (sys_rst_n),
      .ready       (ready),
      .fail        (fail),
      .retry_count (retry_count),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase code plus cycles remaining in timed phases; lock seen through a 2-deep delay line.
   int m_state = 0;
   int m_left  = RST_C;
   int m_retry = 0;
   bit m_d1 = 1'b0, m_d2 = 1'b0, m_lk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_left = RST_C; m_retry = 0; m_d1 = 1'b0; m_d2 = 1'b0;
      end else begin
         m_lk = m_d2;
         m_d2 = m_d1;
         m_d1 = pll_locked;
         if (force_relock) begin
            m_state = 0; m_left = RST_C; m_retry = 0;
         end else if (m_state == 0) begin
            if (m_left == 1) begin m_state = 1; m_left = LOCK_T; end
            else m_left--;
         end else if (m_state == 1 && m_lk) begin
            m_state = 2; m_left = STAB_C;
         end else if ((m_state == 1 && m_left == 1) || (m_state == 2 && !m_lk)) begin
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
            if (MAX_R != 0 && m_retry >= MAX_R) m_state = 4;
            else begin m_state = 0; m_left = RST_C; end
         end else if (m_state == 1) begin
            m_left--;
         end else if (m_state == 2) begin
            if (m_left == 1) begin m_state = 3; m_retry = 0; end
            else m_left--;
         end else if (m_state == 3 && !m_lk) begin
            m_state = 0; m_left = RST_C;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("state",       32'(state),       32'(m_state));
         chk("pll_rst",     32'(pll_rst),     32'(m_state == 0 || m_state == 4));
         chk("sys_rst_n",   32'(sys_rst_n),   32'(m_state == 3));
         chk("ready",       32'(ready),       32'(m_state == 3));
         chk("fail",        32'(fail),        32'(m_state == 4));
         chk("retry_count", 32'(retry_count), 32'(m_retry));
      end
   end

   function automatic logic [31:0] sigv(input int w);
      case (w)
         0:       return 32'(state);
         1:       return 32'(ready);
         2:       return 32'(fail);
         default: return 32'(retry_count);
      endcase
   endfunction

   task automatic wait_for(input string nm, input int w, input logic [31:0] v,
                           input int limit, output int k);
      k = 0;
      while (sigv(w) !== v && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk(nm, sigv(w), v);
   endtask

   task automatic pulse_force();
      force_relock = 1'b1;
      @(negedge clk);
      force_relock = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},   32'(state),       0);
      chk({tag, "_pll_rst"}, 32'(pll_rst),     1);
      chk({tag, "_sysrst"},  32'(sys_rst_n),   0);
      chk({tag, "_ready"},   32'(ready),       0);
      chk({tag, "_fail"},    32'(fail),        0);
      chk({tag, "_retry"},   32'(retry_count), 0);
   endtask

   initial begin
      int k, hi, hold;
      rst_n = 1'b1; pll_locked = 1'b0; force_relock = 1'b0;
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("reset");
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Clean lock
      hi = 0;
      while (pll_rst === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
      chk("pll_rst_width", hi, RST_C);
      repeat (3) @(negedge clk);
      pll_locked = 1'b1;
      wait_for("clean_ready", 1, 1, 60, k);
      chk("lock_to_ready", k, 11);
      chk("clean_retry", 32'(retry_count), 0);

      // Lock loss in RUN
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      wait_for("loss_ready_low", 1, 0, 20, k);
      chk("loss_latency", k + 1, 3);
      chk("loss_retry", 32'(retry_count), 0);
      wait_for("loss_rerun", 1, 1, 60, k);

      // Glitch at STABLE cnt=5
      pulse_force();
      wait_for("glitch_stable", 0, 2, 40, k);
      repeat (3) @(negedge clk);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_state", 32'(state), 0);
      chk("glitch_retry", 32'(retry_count), 1);
      wait_for("glitch_rerun", 1, 1, 60, k);
      chk("glitch_retry_clr", 32'(retry_count), 0);

      // force_relock in RUN, then timeout to FAIL
      force_relock = 1'b1; pll_locked = 1'b0;
      @(negedge clk);
      force_relock = 1'b0;
      chk("force_run_sysrst", 32'(sys_rst_n), 0);
      wait_for("to_fail", 2, 1, 200, k);
      chk("fail_latency", k + 1, 49);
      chk("fail_retry", 32'(retry_count), 2);
      chk("fail_pll_rst", 32'(pll_rst), 1);
      repeat (100) @(negedge clk);
      chk("fail_held", 32'(state), 4);

      // force_relock out of FAIL
      force_relock = 1'b1; pll_locked = 1'b1;
      @(negedge clk);
      force_relock = 1'b0;
      chk("unfail_fail", 32'(fail), 0);
      chk("unfail_retry", 32'(retry_count), 0);
      chk("unfail_state", 32'(state), 0);
      wait_for("unfail_run", 1, 1, 80, k);

      // Async reset mid-STABLE
      pulse_force();
      wait_for("ar_stable", 0, 2, 40, k);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("areset");
      @(negedge clk);
      rst_n = 1'b1;
      wait_for("ar_rerun", 1, 1, 80, k);

      // Random lock traffic
      for (int seg = 0; seg < 80; seg++) begin
         pll_locked = ($urandom_range(0, 3) != 0);
         hold = $urandom_range(1, 40);
         for (int c = 0; c < hold; c++) begin
            force_relock = ($urandom_range(0, 150) == 0);
            @(negedge clk);
         end
      end
      force_relock = 1'b0;
      @(negedge clk);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer end of the PLL lock interface. Runs on the 25 MHz reference clock.
- Drives the PLL reset, watches the asynchronous PLL lock output and filters it.
- Releases a system reset only after lock has been stable for a programmable time.
- On lock loss or lock timeout: re-asserts system reset and retries the PLL, with a bounded retry count and a sticky failure flag.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (>=1).
- LOCK_TIMEOUT, 250000: cycles to wait for synchronized lock before retrying (10 ms at 25 MHz).
- STABLE_CYCLES, 1024: consecutive cycles of synchronized lock required before release (>=1).
- MAX_RETRIES, 7: failed attempts allowed before entering FAIL. 0 means retry forever.

Ports:
- clk  in  1  reference clock (PLL input clock domain).
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL LOCK output, asynchronous to clk.
- force_relock  in  1  single-cycle request to restart the PLL sequence; also clears FAIL.
- pll_rst  out  1  active-high reset to the PLL RST pin.
- sys_rst_n  out  1  active-low system reset, synchronous deassert.
- ready  out  1  high exactly while in RUN.
- fail  out  1  sticky, high while in FAIL.
- retry_count  out  4  failed attempts since the last rst_n, force_relock or reaching RUN; saturates at 15.
- state  out  3  encoded state for debug: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=PLL_RST, pll_rst=1, sys_rst_n=0, ready=0, fail=0, retry_count=0.
  - Counters and synchronizer cleared.
- Lock synchronizer:
  - pll_locked passes through 2 flops to give lk. lk lags the pin by 2 cycles.
  - Only lk is used by the FSM.
- Single shared cycle counter cnt, cleared on every state entry.
- PLL_RST:
  - pll_rst=1, sys_rst_n=0.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If lk=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1, the attempt fails (see "attempt fail").
- STABLE:
  - If lk=0, the attempt fails (glitch during settle counts as a failure).
  - Else if cnt==STABLE_CYCLES-1, go to RUN.
- RUN:
  - sys_rst_n=1 and ready=1, both registered, first high on the cycle state==RUN.
  - retry_count is cleared on entry.
  - If lk=0, the next cycle has sys_rst_n=0 and ready=0, state=PLL_RST. Lock loss in RUN does NOT increment retry_count.
- Attempt fail:
  - retry_count increments (saturating).
  - If MAX_RETRIES!=0 and the incremented value >= MAX_RETRIES, go to FAIL. Otherwise go to PLL_RST.
- FAIL:
  - pll_rst=1 held, sys_rst_n=0, fail=1.
  - Leaves only on force_relock or rst_n.
- force_relock:
  - Sampled high in any state, go to PLL_RST next cycle with sys_rst_n=0, ready=0, fail=0, retry_count=0.
  - Takes priority over every other transition in the same cycle.
- sys_rst_n is 0 in every state except RUN. pll_rst is 1 only in PLL_RST and FAIL.
- lk dropping on the same cycle the STABLE count completes counts as a failure, not RUN (lk checked first).
- Counter width is clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). The counter must not wrap within a state.

Test Plan (bench params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Clean lock:
  - Stimulus: release rst_n; pll_locked rises 3 cycles after pll_rst falls and stays high.
  - Response: pll_rst high exactly 4 cycles; lk high 2 cycles after the pin; STABLE for 8 cycles; then sys_rst_n=1, ready=1, retry_count=0.
- Timeout and fail:
  - Stimulus: pll_locked held 0.
  - Response: two WAIT_LOCK periods of 20 cycles, each preceded by a 4-cycle pll_rst pulse; retry_count goes 1 then 2; state=4, fail=1, pll_rst=1, sys_rst_n=0 held for 100+ cycles.
- Lock loss in RUN:
  - Stimulus: after ready=1, drop pll_locked for 1 cycle.
  - Response: ready and sys_rst_n go low 3 cycles after the pin drops (2 sync + 1 register); a new 4-cycle pll_rst pulse follows; retry_count stays 0; re-reaches RUN.
- Glitch in STABLE:
  - Stimulus: pulse pll_locked low 1 cycle at STABLE cnt=5.
  - Response: retry_count=1, return to PLL_RST, no RUN entry; a clean second attempt reaches RUN and retry_count clears to 0.
- force_relock:
  - Stimulus: in FAIL, pulse force_relock.
  - Response: next cycle fail=0, retry_count=0, state=0; a full sequence completes with lock.
  - Stimulus: in RUN, pulse force_relock.
  - Response: next cycle sys_rst_n=0.
- Async reset mid-STABLE:
  - Stimulus: drop rst_n between clock edges.
  - Response: outputs reach reset values immediately without a clock edge; the sequence restarts from PLL_RST after release.
